sr_excitation_driver: RTL
=========================

Name: sr_excitation_driver

Overview:
Command-side counterpart of the team's SR flip-flop bank: accepts a requested WIDTH-bit target state and generates the per-bit s/r excitation pulses that move the downstream SR flip-flops to that state. It reads the flip-flop outputs back (q_fb), verifies the result after a settle window, and retries or flags an error. It never drives the illegal s=r=1 combination.

Parameters:
WIDTH, 4, number of SR flip-flops driven
PULSE_CYCLES, 1, cycles each s/r pulse is held (>=1)
SETTLE_CYCLES, 2, cycles with s=r=0 before read-back check (>=1)
MAX_RETRY, 3, re-drive attempts after a failed check (>=0)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
tgt_valid  input  1  target request valid
tgt_data  input  WIDTH  requested flip-flop state
tgt_ready  output  1  high when idle; request accepted on tgt_valid & tgt_ready at a clk edge
q_fb  input  WIDTH  read-back of downstream flip-flop q outputs
s  output  WIDTH  per-bit set command (registered)
r  output  WIDTH  per-bit reset command (registered)
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse: target reached
err  output  1  one-cycle pulse: target not reached after MAX_RETRY retries
retry_cnt  output  max(1,$clog2(MAX_RETRY+1))  retries used by the current/last request

Behaviour:
- Reset (async, rst_n=0): state IDLE; s=r=0, done=err=0, retry_cnt=0, busy=0, tgt_ready=1. Asserting rst_n mid-operation forces s=r=0 immediately and abandons the request with no done/err.
- States: IDLE, DRIVE, SETTLE. tgt_ready = (state==IDLE); busy = ~tgt_ready.
- Accept (edge with tgt_valid&tgt_ready): latch target T = tgt_data; clear retry_cnt.
  - If q_fb == T at that edge: stay IDLE, done=1 in the next cycle, s/r stay 0.
  - Else: s <= T & ~q_fb, r <= ~T & q_fb; enter DRIVE.
- DRIVE: s/r held PULSE_CYCLES cycles, then s=r=0 and enter SETTLE.
- SETTLE: s=r=0 for SETTLE_CYCLES cycles. At the edge ending the last settle cycle, compare q_fb to T:
  - match: -> IDLE, done=1 for one cycle (tgt_ready already 1 in that cycle).
  - mismatch, retry_cnt < MAX_RETRY: retry_cnt++, reload s/r from current q_fb as on accept, -> DRIVE.
  - mismatch, retry_cnt == MAX_RETRY: -> IDLE, err=1 for one cycle; retry_cnt holds its value until the next accept.
- Latency, full-change, no retry: accept at edge 0 -> s/r high cycles 1..PULSE_CYCLES -> done high in cycle PULSE_CYCLES+SETTLE_CYCLES+1 (defaults: cycle 4).
- Invariants: (s & r) == 0 every cycle; bits where T equals q_fb get s=r=0 (hold); done and err never coincide; tgt_valid is ignored while busy and is not queued.
- tgt_data changes after acceptance do not affect T.
- MAX_RETRY=0: the first mismatch yields err.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles -> s=r=0, tgt_ready=1, busy=0, done=err=0, retry_cnt=0.
- Bench SR-flop model, q_fb=4'b0000, request T=4'b1010 -> cycle 1: s=1010, r=0000; cycles 2-3: s=r=0; done pulses in cycle 4; q_fb=1010.
- From q_fb=1010, request T=0110 -> s=0100, r=1000 for one cycle, done in cycle 4. Request T=0110 again -> no s/r activity, done in cycle 1.
- Stuck bit: model forces q_fb[0]=0, request T=0001 -> four s pulses on bit 0 (initial + 3 retries); retry_cnt reaches 3; err pulses once; done never asserts.
- Back-pressure: assert tgt_valid with T=1111 while busy -> ignored (tgt_ready=0); accepted only on the first IDLE edge; s & r == 0 checked in every cycle of the run.
- Reset mid-DRIVE (PULSE_CYCLES=3, rst_n low in cycle 2) -> s=r=0 immediately, state IDLE, no done/err; a fresh request afterwards completes normally.

Source files
------------

// File: rtl/sr_excitation_driver_if.sv
// Command/read-back bundle between a requester, the excitation driver and the SR flip-flop bank.
interface sr_excitation_driver_if #(
  parameter int WIDTH     = 4,
  parameter int MAX_RETRY = 3
);
  localparam int RCW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  logic             tgt_valid;
  logic [WIDTH-1:0] tgt_data;
  logic             tgt_ready;
  logic [WIDTH-1:0] q_fb;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] r;
  logic             busy;
  logic             done;
  logic             err;
  logic [RCW-1:0]   retry_cnt;

  modport master (
    output tgt_valid, tgt_data, q_fb,
    input  tgt_ready, s, r, busy, done, err, retry_cnt
  );

  modport slave (
    input  tgt_valid, tgt_data, q_fb,
    output tgt_ready, s, r, busy, done, err, retry_cnt
  );
endinterface

// File: rtl/sr_excitation_driver.sv
// Drives per-bit s/r pulses to move an SR flip-flop bank to a requested state,
// verifies the read-back after a settle window and retries or flags an error.
module sr_excitation_driver #(
  parameter int WIDTH         = 4,
  parameter int PULSE_CYCLES  = 1,
  parameter int SETTLE_CYCLES = 2,
  parameter int MAX_RETRY     = 3
) (
  input logic                   clk,
  input logic                   rst_n,
  sr_excitation_driver_if.slave bus
);

  localparam int RCW  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int CMAX = (PULSE_CYCLES > SETTLE_CYCLES) ? PULSE_CYCLES : SETTLE_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [CW-1:0]  PULSE_LAST  = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0]  SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [RCW-1:0] RETRY_MAX   = RCW'(MAX_RETRY);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SETTLE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] tgt_q,   tgt_d;
  logic [WIDTH-1:0] s_q,     s_d;
  logic [WIDTH-1:0] r_q,     r_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic [RCW-1:0]   retry_q, retry_d;
  logic             done_q,  done_d;
  logic             err_q,   err_d;
  logic             accept;

  // Set only bits that must rise, reset only bits that must fall; the two masks are disjoint.
  function automatic logic [WIDTH-1:0] set_mask(input logic [WIDTH-1:0] t,
                                                 input logic [WIDTH-1:0] q);
    return t & ~q;
  endfunction

  function automatic logic [WIDTH-1:0] reset_mask(input logic [WIDTH-1:0] t,
                                                   input logic [WIDTH-1:0] q);
    return ~t & q;
  endfunction

  assign accept = bus.tgt_valid && (state_q == IDLE);

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    s_d     = '0;
    r_d     = '0;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          tgt_d   = bus.tgt_data;
          retry_d = '0;
          cnt_d   = '0;
          if (bus.q_fb == bus.tgt_data) begin
            done_d = 1'b1;
          end else begin
            s_d     = set_mask(bus.tgt_data, bus.q_fb);
            r_d     = reset_mask(bus.tgt_data, bus.q_fb);
            state_d = DRIVE;
          end
        end
      end
      DRIVE: begin
        if (cnt_q == PULSE_LAST) begin
          cnt_d   = '0;
          state_d = SETTLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          s_d   = s_q;
          r_d   = r_q;
        end
      end
      SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d = '0;
          if (bus.q_fb == tgt_q) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else if (retry_q < RETRY_MAX) begin
            // Re-drive from the current read-back so only still-wrong bits pulse.
            retry_d = retry_q + 1'b1;
            s_d     = set_mask(tgt_q, bus.q_fb);
            r_d     = reset_mask(tgt_q, bus.q_fb);
            state_d = DRIVE;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tgt_q   <= '0;
      s_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      retry_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      s_q     <= s_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.tgt_ready = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.s         = s_q;
  assign bus.r         = r_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.retry_cnt = retry_q;

endmodule
